block_state_arbiter: RTL and testbench

- Owns the single-port block-alive memory (one bit per breakable block).
- Shares that memory between two requesters:
  - the renderer's per-pixel read port, which has absolute priority during active video;
  - the game logic's query/clear request port, which is served only while the renderer is idle.
- Also sequences the level refill (all blocks alive) and tracks the remaining-block count for level-clear detection.

---
 rtl/block_state_arbiter_pkg.sv | 14 +
 rtl/block_state_ram.sv | 25 ++
 rtl/block_state_arbiter.sv | 158 +++++++++++++++
 tb/tb_block_state_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_state_arbiter_pkg.sv
// Block-field geometry and address helpers shared by the arbiter,
// its block-state RAM and the renderer.
package block_state_arbiter_pkg;

    localparam int BLOCK_ROW_COUNT = 7;
    localparam int BLOCK_COL_COUNT = 12;
    localparam int BLOCK_COUNT     = BLOCK_ROW_COUNT * BLOCK_COL_COUNT;
    localparam int ADDR_W          = 7;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_W'(BLOCK_COUNT);
    endfunction

endpackage

// File: rtl/block_state_ram.sv
// Single-port BLOCK_COUNT x 1 alive-bit store: synchronous write, registered read.
// Out-of-range addresses read as 0 and ignore writes.
module block_state_ram
    import block_state_arbiter_pkg::*;
(
    input  logic              i_clk,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_we,
    input  logic              i_wdata,
    output logic              o_rdata
);

    logic r_mem [BLOCK_COUNT];
    logic r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we && addr_in_range(i_addr)) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= addr_in_range(i_addr) ? r_mem[i_addr] : 1'b0;
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/block_state_arbiter.sv
// Shares the block-alive RAM between the renderer (priority during active video)
// and game-logic query/clear requests; sequences level refill and tracks live blocks.
//
// state   | meaning
// --------+---------------------------------------------------------
// FILL    | writing 1 to mem[ptr], one block per idle-video cycle
// IDLE    | waiting for a pending refill or a logic request
// READ    | logic address was presented; capture its alive bit
// WRITE   | clear the live block and decrement the live count
// ACK     | one-cycle completion pulse to game logic
module block_state_arbiter
    import block_state_arbiter_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_render_active,
    input  logic [ADDR_W-1:0] i_render_addr,
    output logic              o_render_alive,
    input  logic              i_logic_req,
    input  logic              i_logic_op,
    input  logic [ADDR_W-1:0] i_logic_addr,
    output logic              o_logic_ack,
    output logic              o_logic_alive,
    input  logic              i_fill_start,
    output logic              o_fill_busy,
    output logic [ADDR_W-1:0] o_alive_count,
    output logic              o_level_clear
);

    typedef enum logic [2:0] {
        ST_FILL  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_ACK   = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BLOCK_COUNT - 1);
    localparam logic [ADDR_W-1:0] FULL_COUNT = ADDR_W'(BLOCK_COUNT);

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_alive_count;
    logic              r_fill_pend;
    logic              r_logic_ack;
    logic              r_logic_alive;
    logic              r_render_valid;
    logic              r_rd_pend;
    logic              r_rd_bit;

    logic [ADDR_W-1:0] w_ram_addr;
    logic              w_ram_we;
    logic              w_ram_wdata;
    logic              w_rd_data;
    logic              w_logic_bit;
    logic              w_fill_busy;

    block_state_ram u_ram (
        .i_clk   (i_clk),
        .i_addr  (w_ram_addr),
        .i_we    (w_ram_we),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_rd_data)
    );

    always_comb begin
        w_ram_addr  = i_logic_addr;
        w_ram_we    = 1'b0;
        w_ram_wdata = 1'b0;
        if (i_render_active) begin
            w_ram_addr = i_render_addr;
        end else if (r_state == ST_FILL) begin
            w_ram_addr  = r_ptr;
            w_ram_we    = 1'b1;
            w_ram_wdata = 1'b1;
        end else if (r_state == ST_WRITE) begin
            w_ram_we = 1'b1;
        end
    end

    // A render edge can land between accept and READ; r_rd_bit keeps the logic read alive.
    assign w_logic_bit = (r_rd_pend ? w_rd_data : r_rd_bit) & addr_in_range(i_logic_addr);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_FILL;
            r_ptr          <= '0;
            r_alive_count  <= '0;
            r_fill_pend    <= 1'b0;
            r_logic_ack    <= 1'b0;
            r_logic_alive  <= 1'b0;
            r_render_valid <= 1'b0;
            r_rd_pend      <= 1'b0;
            r_rd_bit       <= 1'b0;
        end else begin
            r_render_valid <= i_render_active && addr_in_range(i_render_addr);
            r_rd_pend      <= 1'b0;
            if (r_rd_pend) begin
                r_rd_bit <= w_rd_data;
            end
            if (r_state == ST_ACK) begin
                r_logic_ack <= 1'b0;
                r_state     <= ST_IDLE;
            end else if (!i_render_active) begin
                case (r_state)
                    ST_FILL: begin
                        if (r_fill_pend) begin
                            r_ptr       <= '0;
                            r_fill_pend <= 1'b0;
                        end else if (r_ptr == LAST_ADDR) begin
                            r_state       <= ST_IDLE;
                            r_alive_count <= FULL_COUNT;
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end
                    ST_IDLE: begin
                        if (r_fill_pend) begin
                            r_ptr       <= '0;
                            r_fill_pend <= 1'b0;
                            r_state     <= ST_FILL;
                        end else if (i_logic_req) begin
                            r_state   <= ST_READ;
                            r_rd_pend <= 1'b1;
                        end
                    end
                    ST_READ: begin
                        r_logic_alive <= w_logic_bit;
                        if (i_logic_op && w_logic_bit) begin
                            r_state <= ST_WRITE;
                        end else begin
                            r_state     <= ST_ACK;
                            r_logic_ack <= 1'b1;
                        end
                    end
                    ST_WRITE: begin
                        r_alive_count <= r_alive_count - 1'b1;
                        r_state       <= ST_ACK;
                        r_logic_ack   <= 1'b1;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
            if (i_fill_start) begin
                r_fill_pend <= 1'b1;
            end
        end
    end

    assign w_fill_busy    = (r_state == ST_FILL) || r_fill_pend;
    assign o_fill_busy    = w_fill_busy;
    assign o_render_alive = w_rd_data & r_render_valid;
    assign o_logic_ack    = r_logic_ack;
    assign o_logic_alive  = r_logic_alive;
    assign o_alive_count  = r_alive_count;
    assign o_level_clear  = (r_alive_count == '0) && !w_fill_busy;

endmodule

// File: tb/tb_block_state_arbiter.sv
// Directed bench for block_state_arbiter with a bit-array model of the block field
// checked against the DUT on every falling edge.
module tb_block_state_arbiter;

    logic       clk;
    logic       rst_n;
    logic       render_active;
    logic [6:0] render_addr;
    logic       o_render_alive;
    logic       logic_req;
    logic       logic_op;
    logic [6:0] logic_addr;
    logic       o_logic_ack;
    logic       o_logic_alive;
    logic       fill_start;
    logic       o_fill_busy;
    logic [6:0] o_alive_count;
    logic       o_level_clear;

    int total = 0;
    int bad   = 0;

    // model state
    bit m_alive [84];
    int m_count = 0;
    bit m_out   = 0;
    int t_addr  = 0;
    bit t_op    = 0;
    bit exp_render;

    block_state_arbiter dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_render_active (render_active),
        .i_render_addr   (render_addr),
        .o_render_alive  (o_render_alive),
        .i_logic_req     (logic_req),
        .i_logic_op      (logic_op),
        .i_logic_addr    (logic_addr),
        .o_logic_ack     (o_logic_ack),
        .o_logic_alive   (o_logic_alive),
        .i_fill_start    (fill_start),
        .o_fill_busy     (o_fill_busy),
        .o_alive_count   (o_alive_count),
        .o_level_clear   (o_level_clear)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_fill_done();
        for (int i = 0; i < 84; i++) m_alive[i] = 1'b1;
        m_count = 84;
    endtask

    // renderer reads the field as it stood before the edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_render <= 1'b0;
        else exp_render <= (render_active && render_addr < 84) ? m_alive[render_addr] : 1'b0;
    end

    always @(negedge clk) begin
        bit exp_alive;
        if (rst_n) begin
            check("render_alive", o_render_alive, exp_render);
            if (o_logic_ack) begin
                check("ack_outstanding", m_out, 1);
                if (m_out) begin
                    exp_alive = (t_addr < 84) ? m_alive[t_addr] : 1'b0;
                    check("ack_alive_model", o_logic_alive, exp_alive);
                    if (t_op && exp_alive) begin
                        m_alive[t_addr] = 1'b0;
                        m_count--;
                    end
                    m_out = 1'b0;
                end
            end
            check("alive_count_model", o_alive_count, m_count);
        end
    end

    task automatic wait_fill(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (o_fill_busy && n < 300);
    endtask

    task automatic do_req(input bit op, input int addr, input bit toggle, input int fill_at,
                          output int lat, output bit alive);
        t_op       = op;
        t_addr     = addr;
        logic_op   = op;
        logic_addr = 7'(addr);
        logic_req  = 1'b1;
        m_out      = 1'b1;
        lat        = 0;
        do begin
            fill_start = (lat == fill_at);
            if (toggle) begin
                render_active = ~render_active;
                render_addr   = (lat % 4 == 2) ? 7'(addr) : 7'((lat * 11 + 3) % 100);
            end
            tick();
            lat++;
        end while (!o_logic_ack && lat < 40);
        fill_start    = 1'b0;
        alive         = o_logic_alive;
        logic_req     = 1'b0;
        render_active = 1'b0;
        tick();
        check("ack_one_cycle", o_logic_ack, 0);
    endtask

    // expected latency from the rule "only idle-video edges advance the request"
    task automatic req_chk(input string name, input bit op, input int addr,
                           input bit toggle, input int fill_at);
        int lat;
        bit alive;
        bit live;
        int exp_lat;
        live    = (addr < 84) ? m_alive[addr] : 1'b0;
        exp_lat = (op && live) ? 3 : 2;
        if (toggle) exp_lat = exp_lat * 2;
        do_req(op, addr, toggle, fill_at, lat, alive);
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_alive"}, alive, live);
    endtask

    initial begin
        int n;
        int lat;
        bit alive;
        rst_n         = 1'b0;
        render_active = 1'b0;
        render_addr   = '0;
        logic_req     = 1'b0;
        logic_op      = 1'b0;
        logic_addr    = '0;
        fill_start    = 1'b0;
        tick();
        tick();
        check("rst_render_alive", o_render_alive, 0);
        check("rst_ack", o_logic_ack, 0);
        check("rst_logic_alive", o_logic_alive, 0);
        check("rst_count", o_alive_count, 0);
        check("rst_fill_busy", o_fill_busy, 1);
        check("rst_level_clear", o_level_clear, 0);
        rst_n = 1'b1;

        wait_fill(n);
        check("init_fill_cycles", n, 84);
        model_fill_done();
        check("init_count", o_alive_count, 84);
        check("init_level_clear", o_level_clear, 0);

        do_req(1'b0, 5, 1'b0, -1, lat, alive);
        check("query5_lat", lat, 2);
        check("query5_alive", alive, 1);

        do_req(1'b1, 17, 1'b0, -1, lat, alive);
        check("clear17_lat", lat, 3);
        check("clear17_alive", alive, 1);
        check("clear17_count", o_alive_count, 83);
        do_req(1'b1, 17, 1'b0, -1, lat, alive);
        check("reclear17_lat", lat, 2);
        check("reclear17_alive", alive, 0);
        check("reclear17_count", o_alive_count, 83);

        render_active = 1'b1;
        render_addr   = 7'd17;
        tick();
        check("render17", o_render_alive, 0);
        render_addr = 7'd18;
        tick();
        check("render18", o_render_alive, 1);
        render_addr = 7'd100;
        tick();
        check("render100", o_render_alive, 0);
        render_active = 1'b0;
        tick();
        check("render_idle", o_render_alive, 0);

        // alternating video: advancing edges are the 2nd, 4th and 6th
        do_req(1'b1, 30, 1'b1, -1, lat, alive);
        check("toggle_clear30_lat", lat, 6);
        check("toggle_clear30_alive", alive, 1);
        check("toggle_clear30_count", o_alive_count, 82);
        req_chk("toggle_query30", 1'b0, 30, 1'b1, -1);

        do_req(1'b1, 100, 1'b0, -1, lat, alive);
        check("oor_lat", lat, 2);
        check("oor_alive", alive, 0);
        check("oor_count", o_alive_count, 82);

        for (int a = 0; a < 84; a++) req_chk("clear_all", 1'b1, a, 1'b0, -1);
        check("all_clear_count", o_alive_count, 0);
        check("all_clear_level", o_level_clear, 1);

        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        check("refill_busy", o_fill_busy, 1);
        check("refill_level_clear", o_level_clear, 0);
        // one IDLE->FILL hand-over edge, then 84 fill edges
        wait_fill(n);
        check("refill_cycles", n, 85);
        model_fill_done();
        check("refill_count", o_alive_count, 84);
        req_chk("after_refill_query", 1'b0, 17, 1'b0, -1);

        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        repeat (41) tick();
        rst_n = 1'b0;
        #1;
        m_count = 0;
        check("midrst_busy", o_fill_busy, 1);
        check("midrst_count", o_alive_count, 0);
        check("midrst_ack", o_logic_ack, 0);
        check("midrst_render", o_render_alive, 0);
        check("midrst_level_clear", o_level_clear, 0);
        tick();
        rst_n = 1'b1;
        wait_fill(n);
        check("midrst_fill_cycles", n, 84);
        model_fill_done();
        check("midrst_final_count", o_alive_count, 84);

        // FILL_START lands while the clear sits in WRITE
        req_chk("clear50_fill", 1'b1, 50, 1'b0, 2);
        check("clear50_count", o_alive_count, 83);
        check("clear50_busy", o_fill_busy, 1);
        t_op       = 1'b0;
        t_addr     = 50;
        logic_op   = 1'b0;
        logic_addr = 7'd50;
        logic_req  = 1'b1;
        m_out      = 1'b1;
        n          = 0;
        lat        = 0;
        do begin
            tick();
            n++;
            if (o_logic_ack) lat++;
        end while (o_fill_busy && n < 300);
        model_fill_done();
        check("fill_after_write_cycles", n, 85);
        check("no_ack_during_fill", lat, 0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_logic_ack && n < 40);
        check("post_fill_query_lat", n, 2);
        check("post_fill_query_alive", o_logic_alive, 1);
        logic_req = 1'b0;
        tick();
        tick();
        check("final_count", o_alive_count, 84);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
